// File: rtl/montgomery_exp_pkg.sv
// Shared constants for the Montgomery-domain square-and-multiply exponentiation controller.
package montgomery_exp_pkg;

  localparam int N_DEF      = 381;
  localparam int E_BITS_DEF = 381;

  // Width of the bits-remaining counter; it must hold the value E_BITS itself.
  localparam int CNT_W = $clog2(E_BITS_DEF + 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SCAN      = 3'd1;
  localparam logic [2:0] ST_NEXT      = 3'd2;
  localparam logic [2:0] ST_SQ_START  = 3'd3;
  localparam logic [2:0] ST_SQ_WAIT   = 3'd4;
  localparam logic [2:0] ST_MUL_START = 3'd5;
  localparam logic [2:0] ST_MUL_WAIT  = 3'd6;
  localparam logic [2:0] ST_DONE      = 3'd7;

endpackage

// File: rtl/montgomery_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one external Montgomery multiplier.
// Multiplier handshake: mm_start is a one-cycle request; mm_a/mm_b/mm_m are held from the
// mm_start cycle through the mm_done cycle; mm_done is honoured only in the two WAIT states.
module montgomery_exp_ctrl
  import montgomery_exp_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int E_BITS = E_BITS_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [N-1:0]      in_x,
  input  logic [N-1:0]      in_one,
  input  logic [E_BITS-1:0] in_e,
  input  logic [N-1:0]      in_m,
  output logic [N-1:0]      result,
  output logic              done,
  output logic              busy,
  output logic              mm_start,
  output logic [N-1:0]      mm_a,
  output logic [N-1:0]      mm_b,
  output logic [N-1:0]      mm_m,
  input  logic [N-1:0]      mm_result,
  input  logic              mm_done,
  output logic [2:0]        dbg_state,
  output logic              dbg_seen_one
);

  localparam int CW = (E_BITS == E_BITS_DEF) ? CNT_W : $clog2(E_BITS + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(E_BITS);

  logic [2:0]        state;
  logic [N-1:0]      a_reg;
  logic [N-1:0]      x_reg;
  logic [N-1:0]      m_reg;
  logic [N-1:0]      op_a;
  logic [N-1:0]      op_b;
  logic [E_BITS-1:0] e_reg;
  logic [CW-1:0]     cnt;
  logic              seen_one;
  logic              cur_bit;

  assign cur_bit = e_reg[E_BITS-1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      a_reg    <= '0;
      x_reg    <= '0;
      m_reg    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      e_reg    <= '0;
      cnt      <= '0;
      seen_one <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            x_reg    <= in_x;
            m_reg    <= in_m;
            e_reg    <= in_e;
            a_reg    <= in_one;
            cnt      <= CNT_LOAD;
            seen_one <= 1'b0;
            state    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // The leading one needs no R*X product: the accumulator simply becomes X.
          if (cur_bit) begin
            a_reg    <= x_reg;
            seen_one <= 1'b1;
            state    <= ST_NEXT;
          end else if (cnt == CNT_ONE) begin
            state <= ST_DONE;
          end else begin
            e_reg <= e_reg << 1;
            cnt   <= cnt - CNT_ONE;
          end
        end
        ST_NEXT: begin
          if (cnt == CNT_ONE) begin
            state <= ST_DONE;
          end else begin
            e_reg <= e_reg << 1;
            cnt   <= cnt - CNT_ONE;
            op_a  <= a_reg;
            op_b  <= a_reg;
            state <= ST_SQ_START;
          end
        end
        ST_SQ_START: state <= ST_SQ_WAIT;
        ST_SQ_WAIT: begin
          if (mm_done) begin
            a_reg <= mm_result;
            if (cur_bit) begin
              op_a  <= mm_result;
              op_b  <= x_reg;
              state <= ST_MUL_START;
            end else begin
              state <= ST_NEXT;
            end
          end
        end
        ST_MUL_START: state <= ST_MUL_WAIT;
        ST_MUL_WAIT: begin
          if (mm_done) begin
            a_reg <= mm_result;
            state <= ST_NEXT;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign result       = a_reg;
  assign done         = (state == ST_DONE);
  assign busy         = (state != ST_IDLE);
  assign mm_start     = (state == ST_SQ_START) || (state == ST_MUL_START);
  assign mm_a         = op_a;
  assign mm_b         = op_b;
  assign mm_m         = m_reg;
  assign dbg_state    = state;
  assign dbg_seen_one = seen_one;

endmodule

// File: tb/tb_montgomery_exp_ctrl.sv
// Bench for montgomery_exp_ctrl: behavioural Montgomery multiplier stub with variable latency.
module tb_montgomery_exp_ctrl;
  import montgomery_exp_pkg::*;

  localparam int N  = 381;
  localparam int EB = 381;
  localparam logic [N-1:0] BLS_P =
    381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [N-1:0]  in_x, in_one, in_m;
  logic [EB-1:0] in_e;
  logic [N-1:0]  result;
  logic          done, busy, mm_start;
  logic [N-1:0]  mm_a, mm_b, mm_m;
  logic [N-1:0]  mm_result;
  logic          mm_done;
  logic [2:0]    dbg_state;
  logic          dbg_seen_one;

  montgomery_exp_ctrl #(.N(N), .E_BITS(EB)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_x(in_x), .in_one(in_one), .in_e(in_e), .in_m(in_m),
    .result(result), .done(done), .busy(busy),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_result(mm_result), .mm_done(mm_done),
    .dbg_state(dbg_state), .dbg_seen_one(dbg_seen_one)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [N-1:0] exp_q[$];

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic [N-1:0] mont_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [N-1:0] m);
    logic [2*N+1:0] t, aw, bw, mw;
    aw = '0; bw = '0; mw = '0;
    aw[N-1:0] = a;
    bw[N-1:0] = b;
    mw[N-1:0] = m;
    t = aw * bw;
    for (int i = 0; i < N; i++) begin
      if (t[0]) t = t + mw;
      t = t >> 1;
    end
    if (t >= mw) t = t - mw;
    return t[N-1:0];
  endfunction

  function automatic logic [N-1:0] to_mont(input logic [N-1:0] x, input logic [N-1:0] m);
    logic [2*N:0] w, mw;
    w = '0; mw = '0;
    w[N-1:0]  = x;
    mw[N-1:0] = m;
    w = (w << N) % mw;
    return w[N-1:0];
  endfunction

  // Right-to-left ladder: independent of the DUT's left-to-right order.
  function automatic logic [N-1:0] model_exp(input logic [N-1:0] xm, input logic [N-1:0] onem,
                                             input logic [EB-1:0] e, input logic [N-1:0] m);
    logic [N-1:0] acc, base;
    acc  = onem;
    base = xm;
    for (int i = 0; i < EB; i++) begin
      if (e[i]) acc = mont_mul(acc, base, m);
      base = mont_mul(base, base, m);
    end
    return acc;
  endfunction

  function automatic logic [N-1:0] rand_wide();
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < 12; i++) r = (r << 32) | N'($urandom());
    return r;
  endfunction

  // ---------------- multiplier stub ----------------
  int           lat_lo = 1, lat_hi = 1;
  bit           glitch_en = 1'b0;
  bit           pend = 1'b0;
  int           wait_cnt = 0;
  logic [N-1:0] a_lat, b_lat, m_lat;
  int           sq_cnt = 0, mul_cnt = 0, stab_bad = 0;
  logic [63:0]  kind_hist = '0;

  initial begin
    mm_done   = 1'b0;
    mm_result = '0;
  end

  always @(negedge clk) begin
    mm_done = 1'b0;
    if (!resetn) begin
      pend = 1'b0;
    end else if (pend) begin
      if (mm_a !== a_lat || mm_b !== b_lat || mm_m !== m_lat) stab_bad++;
      if (wait_cnt <= 1) begin
        mm_result = mont_mul(a_lat, b_lat, m_lat);
        mm_done   = 1'b1;
        pend      = 1'b0;
      end else begin
        wait_cnt--;
      end
    end else if (mm_start) begin
      pend      = 1'b1;
      wait_cnt  = int'($urandom_range(lat_hi, lat_lo));
      a_lat     = mm_a;
      b_lat     = mm_b;
      m_lat     = mm_m;
      if (mm_a == mm_b) sq_cnt++;
      else mul_cnt++;
      kind_hist = {kind_hist[62:0], mm_a == mm_b};
    end else if (glitch_en && $urandom_range(0, 3) == 0) begin
      mm_done   = 1'b1;
      mm_result = rand_wide();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_start(input logic [N-1:0] x, input logic [N-1:0] one,
                             input logic [EB-1:0] e, input logic [N-1:0] m);
    @(negedge clk);
    in_x = x; in_one = one; in_e = e; in_m = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_exp(input string tag, input logic [N-1:0] x, input logic [N-1:0] one,
                         input logic [EB-1:0] e, input logic [N-1:0] m,
                         input logic [N-1:0] exp_res, input int exp_cyc,
                         input int exp_sq, input int exp_mul,
                         input int hist_len, input logic [63:0] exp_hist, input bit stray);
    int cyc, sq0, mul0, stab0;
    logic [N-1:0] exp_v;
    logic [63:0] mask;
    exp_q.push_back(exp_res);
    sq0 = sq_cnt; mul0 = mul_cnt; stab0 = stab_bad;
    drive_start(x, one, e, m);
    cyc = 1;
    while (done !== 1'b1 && cyc < 40000) begin
      if (stray && cyc == 5) begin
        start = 1'b1; in_x = ~x; in_e = '1; in_one = ~one;
      end else if (stray && cyc == 6) begin
        start = 1'b0; in_x = x; in_e = e; in_one = one;
      end
      @(negedge clk);
      cyc++;
    end
    exp_v = exp_q.pop_front();
    check({tag, "_done_seen"}, done, 1'b1);
    if (exp_cyc >= 0) check({tag, "_latency"}, cyc, exp_cyc);
    check({tag, "_result"}, result, exp_v);
    check({tag, "_busy_in_done"}, busy, 1'b1);
    check({tag, "_squares"}, sq_cnt - sq0, exp_sq);
    check({tag, "_multiplies"}, mul_cnt - mul0, exp_mul);
    check({tag, "_operand_stable"}, stab_bad - stab0, 0);
    if (hist_len > 0) begin
      mask = (64'd1 << hist_len) - 64'd1;
      check({tag, "_order"}, kind_hist & mask, exp_hist);
    end
    // A start raised during the DONE cycle must not be accepted.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_idle_after"}, busy, 1'b0);
    check({tag, "_result_hold"}, result, exp_v);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [EB-1:0] e_big;
    logic [N-1:0]  xr, xm, onem;
    int wcnt;
    resetn = 1'b0;
    start  = 1'b0;
    in_x = '0; in_one = '0; in_e = '0; in_m = '0;
    repeat (3) @(negedge clk);
    check("rst_result", result, '0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_mm_start", mm_start, 1'b0);
    check("rst_mm_a", mm_a, '0);
    check("rst_mm_m", mm_m, '0);
    resetn = 1'b1;
    @(negedge clk);

    // m = 97: R mod 97 = 85, Mont(3) = 61, Mont(5) = 37, Mont(3^5=49) = 91, Mont(5^13=29) = 40.
    run_exp("e0", N'(61), N'(85), EB'(0), N'(97), N'(85), 382, 0, 0, 0, 64'd0, 1'b0);
    run_exp("e1", N'(61), N'(85), EB'(1), N'(97), N'(61), 383, 0, 0, 0, 64'd0, 1'b0);
    run_exp("e5", N'(61), N'(85), EB'(5), N'(97), N'(91), 389, 2, 1, 3, 64'd6, 1'b0);

    lat_lo = 1; lat_hi = 500; glitch_en = 1'b1;
    run_exp("e13_slow", N'(37), N'(85), EB'(13), N'(97), N'(40), -1, 3, 2, 5, 64'd22, 1'b1);
    lat_lo = 2; lat_hi = 9;
    run_exp("e5_glitch", N'(61), N'(85), EB'(5), N'(97), N'(91), -1, 2, 1, 3, 64'd6, 1'b0);

    // Abort in the middle of a squaring, then restart with new operands.
    lat_lo = 500; lat_hi = 500;
    drive_start(N'(37), N'(85), EB'(13), N'(97));
    wcnt = 0;
    while (dbg_state != ST_SQ_WAIT && wcnt < 2000) begin
      @(negedge clk);
      wcnt++;
    end
    check("abort_reached_wait", dbg_state, ST_SQ_WAIT);
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_result", result, '0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_mm_start", mm_start, 1'b0);
    check("abort_mm_a", mm_a, '0);
    check("abort_mm_b", mm_b, '0);
    check("abort_mm_m", mm_m, '0);
    resetn = 1'b1;
    lat_lo = 1; lat_hi = 6;
    run_exp("after_abort", N'(61), N'(85), EB'(5), N'(97), N'(91), -1, 2, 1, 3, 64'd6, 1'b1);

    // Full-width exponent against the BLS12-381 base-field prime.
    glitch_en = 1'b0;
    lat_lo = 1; lat_hi = 3;
    e_big = EB'(rand_wide());
    e_big[EB-1] = 1'b1;
    xr   = rand_wide() % BLS_P;
    xm   = to_mont(xr, BLS_P);
    onem = to_mont(N'(1), BLS_P);
    run_exp("bls", xm, onem, e_big, BLS_P, model_exp(xm, onem, e_big, BLS_P), -1,
            EB - 1, $countones(e_big) - 1, 0, 64'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/montgomery_exp_ctrl.md
Name: montgomery_exp_ctrl

Overview:
- Initiator side of the multiplier start/done handshake: sequences left-to-right square-and-multiply modular exponentiation.
- Issues one Montgomery multiplication at a time to an external multiplier and captures each result.
- All operands and the result are in the Montgomery domain.
- Sits between the ECDSA verify top-level and the Montgomery multiplier instance; the parent wires mm_* ports to the multiplier.

Parameters:
- N, 381, operand/modulus width in bits.
- E_BITS, 381, exponent width in bits.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- start  in  1  single-cycle request; sampled only in IDLE
- in_x  in  N  base, Montgomery form (xR mod m)
- in_one  in  N  R mod m (Montgomery one)
- in_e  in  E_BITS  exponent
- in_m  in  N  modulus
- result  out  N  x^e, Montgomery form
- done  out  1  one-cycle completion pulse
- busy  out  1  high from the cycle after start is accepted until DONE inclusive
- mm_start  out  1  one-cycle pulse to the multiplier
- mm_a  out  N  multiplier operand A
- mm_b  out  N  multiplier operand B
- mm_m  out  N  modulus to the multiplier, = m_reg
- mm_result  in  N  multiplier result
- mm_done  in  1  multiplier completion pulse

Behaviour:
- Reset: one clk edge with resetn=0 forces state=IDLE, done=0, busy=0, mm_start=0, result/A/X/M/e_reg=0, cnt=0.
  - Reset mid-operation aborts immediately; no pending multiplication is tracked afterwards.
- Registers: A (accumulator, drives result), X, M, e_reg (shifts left; current bit = e_reg[E_BITS-1]), cnt (bits remaining including current, width clog2(E_BITS+1)), seen_one.
- IDLE: on start=1, load X=in_x, M=in_m, e_reg=in_e, A=in_one, cnt=E_BITS, seen_one=0 -> SCAN.
- SCAN: one bit per cycle, leading zeros only.
  - Bit 0, cnt==1 -> DONE.
  - Bit 0, cnt>1 -> shift e_reg, cnt--, stay in SCAN.
  - Bit 1 -> A=X (R·X product skipped), seen_one=1 -> NEXT.
- NEXT: cnt==1 -> DONE; else shift e_reg, cnt-- -> SQ_START.
- SQ_START: mm_start=1, mm_a=mm_b=A -> SQ_WAIT.
- SQ_WAIT: on mm_done, A=mm_result; if current bit=1 -> MUL_START, else -> NEXT.
- MUL_START: mm_start=1, mm_a=A, mm_b=X -> MUL_WAIT.
- MUL_WAIT: on mm_done, A=mm_result -> NEXT.
- DONE: done=1 for exactly one cycle -> IDLE; result holds A until the next accepted start.
- Handshake rules:
  - mm_a/mm_b/mm_m remain stable from the mm_start cycle until the cycle after mm_done.
  - mm_done is ignored outside the WAIT states.
  - Multiplier latency is arbitrary (at least 1 cycle).
- start while busy, or in the DONE cycle, is ignored.
- Multiplication count for exponent bit-length L>0 and popcount w: L-1 squarings plus w-1 multiplies.
- Latency without waits:
  - e=0: done in cycle E_BITS+1 after the start cycle; result=in_one; no mm_start.
  - e=1: done in cycle E_BITS+2; result=in_x; no mm_start.
- Width rules: no internal arithmetic except cnt decrement; cnt never wraps (cnt==1 check precedes decrement).

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, SCAN, NEXT, SQ_START, SQ_WAIT, MUL_START, MUL_WAIT, DONE; 3-bit);
  - N/E_BITS defaults;
  - the CNT_W constant.
- No sub-module inside; operand muxing is inline. A thin parent montgomery_exp_top instantiates this block plus the multiplier.

Test Plan:
- Bench drives a Montgomery-multiplier stub with configurable latency.
- e=0, m=97, in_one=R mod 97 -> done at cycle 382; result=in_one; zero mm_start pulses.
- e=1, x=3 -> result=in_x, done at cycle 383, no mm_start.
- e=5 (101b), m=97, x=3·R mod 97 -> exactly 3 mm_start pulses in order square, square, multiply; result converted out of Montgomery form = 49 (3^5 mod 97).
- Random 381-bit e/x, real montgomery multiplier, m = BLS12-381 prime -> result matches golden model; squaring/multiply counts equal L-1 and w-1.
- Stub latency varied 1..500 cycles, extra mm_done pulses injected in non-WAIT states -> result unchanged; mm_a/mm_b stable throughout each wait.
- resetn=0 in SQ_WAIT, then start with new operands; stray start during busy -> outputs zeroed after reset; new run correct; stray start has no effect.
